// File: rtl/dcache_store_port_pkg.sv
// Shared data-cache constants, store size codes, FSM encoding and byte-lane helpers.
// Used by the store buffer, the store port and (later) the load path.
package dcache_store_port_pkg;

  localparam int DCACHE_LINES      = 4;
  localparam int DCACHE_LINE_BYTES = 16;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_REFILL = 3'd3,
    ST_WRITE  = 3'd4
  } dcache_state_t;

  // Size code 3 is not a legal store size and falls back to a full word.
  function automatic logic [3:0] store_byte_mask(input logic [1:0] size,
                                                 input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lo;
      SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_lane_data(input logic [1:0]  size,
                                                  input logic [31:0] value);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{value[7:0]}};
      SIZE_HALF: lanes = {2{value[15:0]}};
      default:   lanes = value;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/dirty/data storage: one combinational read port and one
// write port that installs a whole line, writes a masked word, or clears dirty.
module dcache_array #(
  parameter int LINES      = 4,
  parameter int LINE_BYTES = 16,
  parameter int TAG_W      = 26,
  parameter int WORD_SIZE  = 32,
  localparam int LINE_BITS = 8 * LINE_BYTES,
  localparam int IDX_W     = $clog2(LINES),
  localparam int WSEL_W    = $clog2(LINE_BYTES / (WORD_SIZE / 8)),
  localparam int LANES     = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic                 wr_line_en,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 wr_word_en,
  input  logic [WSEL_W-1:0]    wr_word_sel,
  input  logic [WORD_SIZE-1:0] wr_word,
  input  logic [LANES-1:0]     wr_word_mask,
  input  logic                 clr_dirty
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_line_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= 1'b0;
    end else if (wr_word_en) begin
      dirty_q[wr_index] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[wr_index] <= 1'b0;
    end
  end

  // Tags and line data carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_line_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end else if (wr_word_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_word_mask[b])
          data_q[wr_index][int'(wr_word_sel) * WORD_SIZE + b * 8 +: 8] <= wr_word[b * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_store_port.sv
// Store-side responder of the write-back, write-allocate data cache: one store at a
// time, dirty-victim writeback and line refill over the memory interface.
module dcache_store_port
  import dcache_store_port_pkg::*;
#(
  parameter int WORD_SIZE        = 32,
  parameter int WIDTH            = 32,
  parameter int SIZE_WRITE_WIDTH = 2,
  parameter int LINES            = DCACHE_LINES,
  parameter int LINE_BYTES       = DCACHE_LINE_BYTES,
  localparam int LINE_BITS       = 8 * LINE_BYTES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cache_wenable,
  input  logic [WIDTH-1:0]            cache_physical_address,
  input  logic [WORD_SIZE-1:0]        cache_store_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        store_success,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WIDTH-1:0]            mem_addr,
  output logic [LINE_BITS-1:0]        mem_wdata,
  input  logic                        mem_ready,
  input  logic [LINE_BITS-1:0]        mem_rdata
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WIDTH - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;

  dcache_state_t state_q, state_d;

  logic [WIDTH-1:0]            addr_q;
  logic [WORD_SIZE-1:0]        value_q;
  logic [SIZE_WRITE_WIDTH-1:0] size_q;

  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic [1:0]        req_lo;

  assign req_lo    = addr_q[1:0];
  assign req_wsel  = addr_q[OFF_W-1:2];
  assign req_index = addr_q[OFF_W +: IDX_W];
  assign req_tag   = addr_q[WIDTH-1 -: TAG_W];

  logic                 rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 wr_line_en, wr_word_en, clr_dirty;

  assign hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Request is captured once; everything after acceptance works from this copy.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && cache_wenable) begin
      addr_q  <= cache_physical_address;
      value_q <= cache_store_value;
      size_q  <= cache_store_size;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cache_wenable) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)                       state_d = ST_WRITE;
        else if (rd_valid && rd_dirty) state_d = ST_WB;
        else                           state_d = ST_REFILL;
      end
      ST_WB:     if (mem_ready) state_d = ST_REFILL;
      ST_REFILL: if (mem_ready) state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The victim tag and line stay put during WB, so the memory outputs are stable.
  always_comb begin
    store_success = 1'b0;
    busy          = (state_q != ST_IDLE);
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wr_line_en    = 1'b0;
    wr_word_en    = 1'b0;
    clr_dirty     = 1'b0;
    case (state_q)
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, req_index, {OFF_W{1'b0}}};
        mem_wdata = rd_line;
        clr_dirty = mem_ready;
      end
      ST_REFILL: begin
        mem_req    = 1'b1;
        mem_addr   = {req_tag, req_index, {OFF_W{1'b0}}};
        wr_line_en = mem_ready;
      end
      ST_WRITE: begin
        wr_word_en    = 1'b1;
        store_success = 1'b1;
      end
      default: ;
    endcase
  end

  dcache_array #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES),
    .TAG_W      (TAG_W),
    .WORD_SIZE  (WORD_SIZE)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .rd_index     (req_index),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_line      (rd_line),
    .wr_index     (req_index),
    .wr_line_en   (wr_line_en),
    .wr_tag       (req_tag),
    .wr_line      (mem_rdata),
    .wr_word_en   (wr_word_en),
    .wr_word_sel  (req_wsel),
    .wr_word      (store_lane_data(size_q, value_q)),
    .wr_word_mask (store_byte_mask(size_q, req_lo)),
    .clr_dirty    (clr_dirty)
  );

endmodule

// File: tb/tb_dcache_store_port.sv
// Scoreboard bench for dcache_store_port: a reference cache model predicts the memory
// transactions and completions of every store; a memory responder serves them.
module tb_dcache_store_port;
  import dcache_store_port_pkg::*;

  localparam int K_WB = 0;
  localparam int K_RD = 1;
  localparam int K_OK = 2;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cache_wenable;
  logic [31:0]  cache_physical_address;
  logic [31:0]  cache_store_value;
  logic [1:0]   cache_store_size;
  logic         store_success, busy, mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_store_port dut (
    .clk                    (clk),
    .reset                  (reset),
    .cache_wenable          (cache_wenable),
    .cache_physical_address (cache_physical_address),
    .cache_store_value      (cache_store_value),
    .cache_store_size       (cache_store_size),
    .store_success          (store_success),
    .busy                   (busy),
    .mem_req                (mem_req),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_ready              (mem_ready),
    .mem_rdata              (mem_rdata)
  );

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [25:0]  m_tag   [4];
  logic         m_valid [4];
  logic         m_dirty [4];
  logic [127:0] m_line  [4];
  logic [127:0] bmem [logic [31:0]];
  logic [127:0] last_wb;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fetch(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a ^ 32'hA5A50303, a ^ 32'h5A5A0202, a ^ 32'h0F0F0101, a ^ 32'hF0F00000};
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] v,
                             input logic [1:0] sz, output bit hit);
    logic [1:0]   idx;
    logic [25:0]  tag;
    logic [127:0] line;
    logic [31:0]  la;
    bit           en;
    logic [7:0]   bv;
    idx = a[5:4];
    tag = a[31:6];
    la  = {a[31:4], 4'h0};
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_q.push_back('{K_WB, {m_tag[idx], idx, 4'h0}, m_line[idx]});
        bmem[{m_tag[idx], idx, 4'h0}] = m_line[idx];
      end
      exp_q.push_back('{K_RD, la, 128'h0});
      m_line[idx]  = fetch(la);
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
    end
    line = m_line[idx];
    for (int b = 0; b < 4; b++) begin
      case (sz)
        2'd0:    begin en = (b == int'(a[1:0])); bv = v[7:0]; end
        2'd1:    begin en = ((b / 2) == int'(a[1])); bv = (b % 2 == 1) ? v[15:8] : v[7:0]; end
        default: begin en = 1'b1; bv = v[b * 8 +: 8]; end
      endcase
      if (en) line[int'(a[3:2]) * 32 + b * 8 +: 8] = bv;
    end
    m_line[idx]  = line;
    m_dirty[idx] = 1'b1;
    exp_q.push_back('{K_OK, 32'h0, 128'h0});
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 1, 0);
      e = '{-1, 32'h0, 128'h0};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] v,
                          input logic [1:0] sz, input int delay);
    bit   hit, done, in_req;
    int   n, cnt, rdy_n;
    exp_t cur, fin;
    model_store(a, v, sz, hit);
    @(negedge clk);
    cache_wenable          = 1'b1;
    cache_physical_address = a;
    cache_store_value      = v;
    cache_store_size       = sz;
    done = 0; in_req = 0; n = 0; cnt = 0; rdy_n = -100;
    cur = '{-1, 32'h0, 128'h0};
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_ready) begin
        mem_ready = 1'b0;
        in_req    = 0;
      end
      if (store_success) begin
        pop_exp(fin);
        check("completion_kind", fin.kind, K_OK);
        if (hit) check("hit_latency", n, 2);
        else     check("miss_latency", n, rdy_n + 1);
        cache_wenable = 1'b0;
        done = 1;
      end else if (mem_req && !in_req) begin
        pop_exp(cur);
        check("req_kind", mem_we ? K_WB : K_RD, cur.kind);
        check("req_addr", mem_addr, cur.addr);
        if (mem_we) begin
          check("wb_data", mem_wdata, cur.data);
          last_wb = mem_wdata;
        end
        in_req = 1;
        cnt    = 0;
      end
      if (in_req && !done) begin
        check("req_hold", {mem_req, mem_we, mem_addr}, {1'b1, cur.kind == K_WB, cur.addr});
        if (cnt == delay) begin
          mem_ready = 1'b1;
          mem_rdata = (cur.kind == K_RD) ? fetch(cur.addr) : ~128'h0;
          rdy_n     = n;
        end
        cnt++;
      end
    end
    if (!done) check("store_timeout", 0, 1);
    @(negedge clk);
    check("single_pulse_idle", {store_success, busy, mem_req}, 3'b000);
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    int n;
    @(negedge clk);
    cache_wenable          = 1'b1;
    cache_physical_address = a;
    cache_store_value      = 32'hCAFEF00D;
    cache_store_size       = SIZE_WORD;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_refill_seen", {mem_req, mem_we, mem_addr}, {2'b10, a[31:4], 4'h0});
    repeat (3) begin
      @(negedge clk);
      check("rst_refill_nosucc", store_success, 0);
    end
    reset         = 1'b1;
    cache_wenable = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {mem_req, busy, store_success}, 3'b000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      check("rst_after_quiet", {mem_req, busy, store_success}, 3'b000);
    end
  endtask

  initial begin
    reset = 1'b1; cache_wenable = 1'b0; cache_physical_address = '0;
    cache_store_value = '0; cache_store_size = '0; mem_ready = 1'b0; mem_rdata = '0;
    last_wb = '0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {store_success, busy, mem_req, mem_we}, 4'b0000);
    check("reset_addr", mem_addr, 0);
    check("reset_wdata", mem_wdata, 0);

    do_store(32'h104, 32'hDEADBEEF, SIZE_WORD, 2);
    do_store(32'h104, 32'h11223344, SIZE_WORD, 0);
    do_store(32'h204, 32'h55667788, SIZE_WORD, 0);
    check("evict_word1", last_wb[63:32], 32'h11223344);

    do_store(32'h108, 32'hAABBCCDD, SIZE_WORD, 1);
    do_store(32'h10B, 32'h0000005A, SIZE_BYTE, 0);
    do_store(32'h108, 32'h00001234, SIZE_HALF, 0);
    do_store(32'h208, 32'h01020304, SIZE_WORD, 0);
    check("merged_word2", last_wb[95:64], 32'h5ABB1234);

    do_store(32'h120, 32'h13579BDF, SIZE_WORD, 10);
    do_store(32'h126, 32'h0000BEEF, SIZE_HALF, 0);
    do_store(32'h123, 32'h0BADF00D, 2'd3, 0);
    do_store(32'h1A0, 32'h24681357, SIZE_WORD, 3);
    check("size3_word0", last_wb[31:0], 32'h0BADF00D);
    check("half_word1", last_wb[63:48], 16'hBEEF);

    reset_mid_refill(32'h330);
    exp_q.delete();
    do_store(32'h330, 32'h77778888, SIZE_WORD, 1);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = {24'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      do_store(a, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
